// File: rtl/chunked_seq_adder_if.sv
// rtl/chunked_seq_adder_if.sv - operand/result handshake bundle for chunked_seq_adder
interface chunked_seq_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/chunked_seq_adder.sv
// rtl/chunked_seq_adder.sv - multi-cycle add/subtract, CHUNK bits per clock
// Optional early termination on zero upper chunks: ADDER_EARLY_TERM_EN
module chunked_seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  chunked_seq_adder_if.slave  bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_ins;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
  logic             msb_c;
  logic             last;
  logic             early;
  logic             accept;
  int               shamt;

  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.overflow  = ovf_r;
  assign accept        = bus.in_valid && bus.in_ready;

  // Operands shift right each BUSY cycle, so the live chunk is always at the bottom.
  always_comb begin
    {chunk_c, chunk_s} = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]}
                       + (CHUNK+1)'(carry_r);
    msb_c   = chunk_s[CHUNK-1] ^ a_r[CHUNK-1] ^ b_r[CHUNK-1];
    last    = (idx == IW'(NCH-1));
    shamt   = int'(idx) * CHUNK;
    sum_ins = (sum_r & ~(WIDTH'({CHUNK{1'b1}}) << shamt))
            | (WIDTH'(chunk_s) << shamt);
`ifdef ADDER_EARLY_TERM_EN
    early   = !last && !chunk_c && (((a_r | b_r) >> CHUNK) == '0);
`else
    early   = 1'b0;
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (last || early) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub | bus.cin;
            sum_r   <= '0;
            idx     <= '0;
          end
        end
        BUSY: begin
          a_r     <= a_r >> CHUNK;
          b_r     <= b_r >> CHUNK;
          carry_r <= chunk_c;
          sum_r   <= sum_ins;
          idx     <= idx + 1'b1;
          if (early) begin
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
          end else if (last) begin
            cout_r <= chunk_c;
            ovf_r  <= msb_c ^ chunk_c;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chunked_seq_adder.sv
// tb/tb_chunked_seq_adder.sv - directed self-checking bench for chunked_seq_adder
module tb_chunked_seq_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  chunked_seq_adder_if #(.WIDTH(32)) bus ();

  chunked_seq_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [31:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.sub = sub;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check({tag, ".sum"}, 64'(bus.sum), 64'(exp_sum));
    check({tag, ".cout"}, 64'(bus.cout), 64'(exp_cout));
    check({tag, ".ovf"}, 64'(bus.overflow), 64'(exp_ovf));
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ".ov_clr"}, 64'(bus.out_valid), 64'd0);
    check({tag, ".sum_hold"}, 64'(bus.sum), 64'(exp_sum));
  endtask

  int lat_small;
  int lat_ff;

  initial begin
`ifdef ADDER_EARLY_TERM_EN
    lat_small = 1;
    lat_ff    = 2;
`else
    lat_small = 4;
    lat_ff    = 4;
`endif
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready_low", 64'(bus.in_ready), 64'd0);
    check("rst.sum", 64'(bus.sum), 64'd0);
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.cout", 64'(bus.cout), 64'd0);
    check("rst.ovf", 64'(bus.overflow), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready_high", 64'(bus.in_ready), 64'd1);

    run_op("ripple", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4);
    run_op("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 4);
    run_op("sub_ok", 32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0, 4);
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 4);
    run_op("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4);
    run_op("cin_add", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 4);
    run_op("small", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, lat_small);
    run_op("ff_plus1", 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, lat_ff);

    // Backpressure: hold result while new operands are offered.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 32'h1111_1111;
    bus.b = 32'h2222_2222;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'h0BAD_F00D;
    begin
      int lat;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
      check("bp.lat", 64'(lat), 64'd4);
    end
    for (int i = 0; i < 10; i++) begin
      check("bp.out_valid", 64'(bus.out_valid), 64'd1);
      check("bp.sum", 64'(bus.sum), 64'h3333_3333);
      check("bp.cout", 64'(bus.cout), 64'd0);
      check("bp.in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp.ov_clr", 64'(bus.out_valid), 64'd0);
    check("bp.in_ready", 64'(bus.in_ready), 64'd1);
    check("bp.sum_hold", 64'(bus.sum), 64'h3333_3333);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp.no_accept", 64'(bus.in_ready), 64'd1);

    // Reset in the middle of an operation.
    bus.in_valid = 1'b1;
    bus.a = 32'h1234_5678;
    bus.b = 32'h1111_1111;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid.in_ready_low", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("mid.sum", 64'(bus.sum), 64'd0);
    check("mid.out_valid", 64'(bus.out_valid), 64'd0);
    check("mid.in_ready_rst", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check("mid.in_ready_high", 64'(bus.in_ready), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid.no_result", 64'(bus.out_valid), 64'd0);
    run_op("after_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, lat_small);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
